// File: rtl/arvi_mem_pkg.sv
// Shared types and funct3 decoding for the memory stage (mem_lsu, mem_align).
package arvi_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [3:0] be_t;

    function automatic logic f3_legal(input logic i_we, input logic [2:0] i_f3);
        if (i_we)
            return (i_f3 == F3_B) || (i_f3 == F3_H) || (i_f3 == F3_W);
        return (i_f3 == F3_B) || (i_f3 == F3_H) || (i_f3 == F3_W) ||
               (i_f3 == F3_BU) || (i_f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] i_f3, input logic [1:0] i_off);
        case (i_f3[1:0])
            2'b01:   return i_off[0];
            2'b10:   return i_off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables / data steering and load extraction / extension.
module mem_align
    import arvi_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_st_size,
    input  logic [1:0]      i_st_off,
    input  logic [XLEN-1:0] i_wdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    input  logic [2:0]      i_ld_f3,
    input  logic [1:0]      i_ld_off,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_st_size)
            2'b00: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    always_comb begin
        case (i_ld_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_ld_f3)
            F3_B:    o_rdata = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_rdata = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_rdata = {{(XLEN-16){1'b0}}, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one req/ack bus transaction per op, stalls until done.
// Optional misaligned-access trap: define MEM_LSU_MISALIGN_TRAP_EN.
module mem_lsu
    import arvi_mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_we,
    input  logic [2:0]      i_f3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_stall,
    output logic            o_err,
    output logic            o_misaligned,
    output logic            o_bus_en,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [3:0]      o_bus_be,
    input  logic [XLEN-1:0] i_bus_rdata,
    input  logic            i_bus_ack
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_bus_en;
    logic            r_bus_we;
    logic [XLEN-1:0] r_bus_addr;
    logic [XLEN-1:0] r_bus_wdata;
    be_t             r_bus_be;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_legal;
    logic            w_timeout;
    be_t             w_be;
    logic [XLEN-1:0] w_st_data;
    logic [XLEN-1:0] w_ld_data;

    mem_align #(.XLEN(XLEN)) u_align (
        .i_st_size (i_f3[1:0]),
        .i_st_off  (i_addr[1:0]),
        .i_wdata   (i_wdata),
        .o_be      (w_be),
        .o_wdata   (w_st_data),
        .i_ld_f3   (r_f3),
        .i_ld_off  (r_off),
        .i_rdata   (i_bus_rdata),
        .o_rdata   (w_ld_data)
    );

    assign w_legal   = f3_legal(i_we, i_f3);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic r_mis;
    logic w_mis;
    assign w_mis        = is_misaligned(i_f3, i_addr[1:0]);
    assign o_misaligned = r_mis;

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_mis <= 1'b0;
        else
            r_mis <= (r_state == ST_IDLE) && i_en && w_legal && w_mis;
    end
`else
    logic w_mis;
    assign w_mis        = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    // Result registers default to 0 every cycle and are loaded only on the edge into DONE,
    // so they read back as 0 everywhere outside DONE.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bus_en    <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_f3        <= '0;
            r_off       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_en) begin
                        if (!w_legal) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_mis) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_bus_en    <= 1'b1;
                            r_bus_we    <= i_we;
                            r_bus_addr  <= {i_addr[XLEN-1:2], 2'b00};
                            r_bus_wdata <= w_st_data;
                            r_bus_be    <= w_be;
                            r_f3        <= i_f3;
                            r_off       <= i_addr[1:0];
                            r_cnt       <= '0;
                            r_state     <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '1)
                        r_cnt <= r_cnt + CW'(1);
                    if (i_bus_ack) begin
                        r_bus_en <= 1'b0;
                        r_state  <= ST_DONE;
                        if (!r_bus_we)
                            r_rdata <= w_ld_data;
                    end else if (w_timeout) begin
                        r_bus_en <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_stall     = i_en && (r_state != ST_DONE);
    assign o_rdata     = r_rdata;
    assign o_err       = r_err;
    assign o_bus_en    = r_bus_en;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_be    = r_bus_be;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, hand sequences, and random ops vs a reference model.
module tb_mem_lsu;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_en = 1'b0;
    logic        i_we = 1'b0;
    logic [2:0]  i_f3 = '0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] o_rdata;
    logic        o_stall;
    logic        o_err;
    logic        o_misaligned;
    logic        o_bus_en;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic [31:0] i_bus_rdata = '0;
    logic        i_bus_ack = 1'b0;

    mem_lsu #(.XLEN(32), .TIMEOUT(TO)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_we         (i_we),
        .i_f3         (i_f3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_rdata      (o_rdata),
        .o_stall      (o_stall),
        .o_err        (o_err),
        .o_misaligned (o_misaligned),
        .o_bus_en     (o_bus_en),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_be     (o_bus_be),
        .i_bus_rdata  (i_bus_rdata),
        .i_bus_ack    (i_bus_ack)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_n;   // BUSY cycle (1-based) carrying ack; 0 = never
    } op_t;

    typedef struct {
        logic        bus;
        logic        we;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          stall;
    } res_t;

    typedef struct {
        op_t  op;
        res_t exp;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic res_t zero_res();
        res_t r;
        r.bus = 0; r.we = 0; r.baddr = '0; r.be = '0; r.bwdata = '0;
        r.rdata = '0; r.err = 0; r.mis = 0; r.stall = 0;
        return r;
    endfunction

    function automatic op_t mkop(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int ack_n);
        op_t o;
        o.we = we; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.rdata = rdata; o.ack_n = ack_n;
        return o;
    endfunction

    function automatic res_t mkres(input logic bus, input logic we, input logic [31:0] baddr,
                                   input logic [3:0] be, input logic [31:0] bwdata, input logic [31:0] rdata,
                                   input logic err, input logic mis, input int stall);
        res_t r;
        r.bus = bus; r.we = we; r.baddr = baddr; r.be = be; r.bwdata = bwdata;
        r.rdata = rdata; r.err = err; r.mis = mis; r.stall = stall;
        return r;
    endfunction

    // Reference model: derived from the access rules with plain arithmetic.
    function automatic res_t model(input op_t op);
        res_t        e;
        bit          legal;
        int          nbytes;
        int          off;
        int          busy;
        bit          tmo;
        logic [31:0] mask;
        logic [31:0] v;
        e = zero_res();
        legal  = op.we ? (op.f3 <= 3'd2) : (op.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nbytes = (op.f3[1:0] == 2'd0) ? 1 : (op.f3[1:0] == 2'd1) ? 2 : 4;
        off    = int'(op.addr % 4);
        if (!legal) begin
            e.err = 1; e.stall = 1;
            return e;
        end
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        if (off % nbytes != 0) begin
            e.mis = 1; e.stall = 1;
            return e;
        end
`endif
        off   = off - (off % nbytes);
        mask  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        e.bus = 1;
        e.we  = op.we;
        e.baddr = op.addr - (op.addr % 4);
        e.be  = 4'(((1 << nbytes) - 1) << off);
        v = op.wdata & mask;
        e.bwdata = '0;
        for (int k = 0; k < 4 / nbytes; k++)
            e.bwdata = e.bwdata | (v << (8 * nbytes * k));
        tmo  = !(op.ack_n >= 1 && op.ack_n <= TO);
        busy = tmo ? TO : op.ack_n;
        e.stall = 1 + busy;
        if (tmo) begin
            e.err = 1;
        end else if (!op.we) begin
            v = (op.rdata >> (8 * off)) & mask;
            if (nbytes < 4 && !op.f3[2] && v[8 * nbytes - 1])
                v = v | ~mask;
            e.rdata = v;
        end
        return e;
    endfunction

    // Entered just after a rising edge with the DUT in IDLE; returns just after the edge leaving DONE.
    task automatic run_op(input op_t op, input bit keep, output res_t r, output int glitch, output bit hung);
        int busy_n;
        bit done;
        busy_n = 0; done = 0; glitch = 0; hung = 0;
        r = zero_res();
        i_en = 1; i_we = op.we; i_f3 = op.f3; i_addr = op.addr; i_wdata = op.wdata;
        i_bus_rdata = op.rdata; i_bus_ack = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge i_clk);
            if (!o_stall) begin
                r.rdata = o_rdata; r.err = o_err; r.mis = o_misaligned;
                done = 1;
                break;
            end
            r.stall++;
            if (o_err || o_misaligned || o_rdata != 0)
                glitch++;
            if (o_bus_en) begin
                busy_n++;
                if (!r.bus) begin
                    r.bus = 1; r.we = o_bus_we; r.baddr = o_bus_addr;
                    r.be = o_bus_be; r.bwdata = o_bus_wdata;
                end else if ({o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata} !==
                             {r.we, r.baddr, r.be, r.bwdata}) begin
                    glitch++;
                end
                i_bus_ack = (busy_n == op.ack_n);
            end
        end
        hung = !done;
        @(posedge i_clk);
        #1;
        i_bus_ack = 0;
        if (!keep)
            i_en = 0;
    endtask

    task automatic compare(input string tag, input res_t g, input res_t e, input int glitch, input bit hung);
        chk({tag, "/hang"},   32'(hung), 32'd0);
        chk({tag, "/stall"},  32'(g.stall), 32'(e.stall));
        chk({tag, "/bus"},    32'(g.bus), 32'(e.bus));
        chk({tag, "/err"},    32'(g.err), 32'(e.err));
        chk({tag, "/mis"},    32'(g.mis), 32'(e.mis));
        chk({tag, "/rdata"},  g.rdata, e.rdata);
        chk({tag, "/stable"}, 32'(glitch), 32'd0);
        if (e.bus) begin
            chk({tag, "/baddr"}, g.baddr, e.baddr);
            chk({tag, "/be"},    32'(g.be), 32'(e.be));
            chk({tag, "/we"},    32'(g.we), 32'(e.we));
            if (e.we)
                chk({tag, "/bwdata"}, g.bwdata, e.bwdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        res_t got;
        res_t e1;
        int   gl;
        bit   hg;
        op_t  op;
        bit   seen;
        bit   keep;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst/bus_en", 32'(o_bus_en), 32'd0);
        chk("rst/stall",  32'(o_stall), 32'd0);
        chk("rst/outs",   {o_rdata ^ o_bus_addr ^ o_bus_wdata}, 32'd0);
        chk("rst/flags",  32'({o_err, o_misaligned, o_bus_we, o_bus_be}), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1;
        @(posedge i_clk);
        #1;

        v.op = mkop(0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
        v.exp = mkres(1, 0, 32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 0, 2); vecs.push_back(v);
        v.op = mkop(0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 1);
        v.exp = mkres(1, 0, 32'h100, 4'h8, 32'h0, 32'hFFFF_FF80, 0, 0, 2); vecs.push_back(v);
        v.op = mkop(0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 1);
        v.exp = mkres(1, 0, 32'h100, 4'h8, 32'h0, 32'h0000_0080, 0, 0, 2); vecs.push_back(v);
        v.op = mkop(0, 3'b101, 32'h102, 32'h0, 32'h80FF_FFFF, 1);
        v.exp = mkres(1, 0, 32'h100, 4'hC, 32'h0, 32'h0000_80FF, 0, 0, 2); vecs.push_back(v);
        v.op = mkop(1, 3'b000, 32'h201, 32'h0000_00AB, 32'h0, 1);
        v.exp = mkres(1, 1, 32'h200, 4'h2, 32'hABAB_ABAB, 32'h0, 0, 0, 2); vecs.push_back(v);
        v.op = mkop(0, 3'b010, 32'h300, 32'h0, 32'h1234_5678, 0);
        v.exp = mkres(1, 0, 32'h300, 4'hF, 32'h0, 32'h0, 1, 0, 5); vecs.push_back(v);
        v.op = mkop(0, 3'b010, 32'h300, 32'h0, 32'h1234_5678, 4);
        v.exp = mkres(1, 0, 32'h300, 4'hF, 32'h0, 32'h1234_5678, 0, 0, 5); vecs.push_back(v);
        v.op = mkop(0, 3'b011, 32'h100, 32'h0, 32'h1111_1111, 1);
        v.exp = mkres(0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0, 1); vecs.push_back(v);
        v.op = mkop(1, 3'b100, 32'h100, 32'h55, 32'h0, 1);
        v.exp = mkres(0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0, 1); vecs.push_back(v);
        v.op = mkop(1, 3'b001, 32'h102, 32'h5555_1234, 32'h0, 1);
        v.exp = mkres(1, 1, 32'h100, 4'hC, 32'h1234_1234, 32'h0, 0, 0, 2); vecs.push_back(v);
        v.op = mkop(0, 3'b001, 32'h100, 32'h0, 32'h0000_8001, 2);
        v.exp = mkres(1, 0, 32'h100, 4'h3, 32'h0, 32'hFFFF_8001, 0, 0, 3); vecs.push_back(v);
        v.op = mkop(1, 3'b010, 32'h104, 32'hA5A5_0F0F, 32'h0, 3);
        v.exp = mkres(1, 1, 32'h104, 4'hF, 32'hA5A5_0F0F, 32'h0, 0, 0, 4); vecs.push_back(v);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        v.op = mkop(0, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 1);
        v.exp = mkres(0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, 1); vecs.push_back(v);
        v.op = mkop(0, 3'b101, 32'h101, 32'h0, 32'h1234_ABCD, 1);
        v.exp = mkres(0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, 1); vecs.push_back(v);
`else
        v.op = mkop(0, 3'b010, 32'h102, 32'h0, 32'hCAFE_F00D, 1);
        v.exp = mkres(1, 0, 32'h100, 4'hF, 32'h0, 32'hCAFE_F00D, 0, 0, 2); vecs.push_back(v);
        v.op = mkop(0, 3'b101, 32'h101, 32'h0, 32'h1234_ABCD, 1);
        v.exp = mkres(1, 0, 32'h100, 4'h3, 32'h0, 32'h0000_ABCD, 0, 0, 2); vecs.push_back(v);
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].op, 0, got, gl, hg);
            compare($sformatf("vec%0d", i), got, vecs[i].exp, gl, hg);
        end

        // Back-to-back: i_en stays high across DONE into the next op
        run_op(vecs[0].op, 1, got, gl, hg);
        compare("b2b0", got, vecs[0].exp, gl, hg);
        run_op(vecs[4].op, 0, got, gl, hg);
        compare("b2b1", got, vecs[4].exp, gl, hg);

        // Reset while BUSY, then a stray ack must be ignored
        i_en = 1; i_we = 0; i_f3 = 3'b010; i_addr = 32'h400; i_bus_ack = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge i_clk);
            seen = o_bus_en;
        end
        chk("rstmid/busy_seen", 32'(seen), 32'd1);
        i_rst = 0;
        @(posedge i_clk);
        #1;
        chk("rstmid/bus_en", 32'(o_bus_en), 32'd0);
        chk("rstmid/stall_idle", 32'(o_stall), 32'd1);
        i_rst = 1; i_en = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            i_bus_ack = 1;
            chk("stray/bus_en", 32'(o_bus_en), 32'd0);
            chk("stray/res", o_rdata | 32'({o_err, o_misaligned, o_stall}), 32'd0);
        end
        @(posedge i_clk);
        #1 i_bus_ack = 0;
        run_op(vecs[1].op, 0, got, gl, hg);
        compare("after_rst", got, vecs[1].exp, gl, hg);

        // Randomized ops against the reference model
        for (int n = 0; n < 300; n++) begin
            op.we = 1'($urandom % 2);
            if ($urandom % 5 == 0)
                op.f3 = 3'($urandom % 8);
            else if (op.we)
                op.f3 = 3'($urandom % 3);
            else
                op.f3 = ($urandom % 2) ? 3'($urandom % 3) : 3'(4 + $urandom % 2);
            op.addr  = $urandom;
            op.wdata = $urandom;
            op.rdata = $urandom;
            op.ack_n = int'($urandom_range(0, 6));
            keep = 1'($urandom % 3 == 0) && (n != 299);
            e1 = model(op);
            run_op(op, keep, got, gl, hg);
            compare($sformatf("rnd%0d", n), got, e1, gl, hg);
        end
        i_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit forming the memory stage directly downstream of the execute stage. It takes the execute result as the effective address and rs2 as store data, and runs one request/acknowledge transaction on the data bus. It stalls the pipeline until that transaction completes, then returns load data sign- or zero-extended to XLEN. It also flags bus timeouts, illegal funct3 codes and, optionally, misaligned accesses.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TIMEOUT, 255, maximum number of BUSY cycles to wait for i_bus_ack; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- i_en  in  1  memory op valid; held high by the pipeline while o_stall is high
- i_we  in  1  1 = store, 0 = load
- i_f3  in  3  funct3: access size and signedness
- i_addr  in  XLEN  effective address (execute stage result)
- i_wdata  in  XLEN  store data (rs2)
- o_rdata  out  XLEN  extended load data; valid in DONE
- o_stall  out  1  pipeline stall request
- o_err  out  1  bus timeout or illegal funct3; pulses in DONE
- o_misaligned  out  1  misaligned access; pulses in DONE (only with MEM_LSU_MISALIGN_TRAP_EN)
- o_bus_en  out  1  bus request
- o_bus_we  out  1  bus write
- o_bus_addr  out  XLEN  word-aligned address, bits [1:0] = 0
- o_bus_wdata  out  XLEN  lane-steered store data
- o_bus_be  out  4  byte enables
- i_bus_rdata  in  XLEN  bus read data
- i_bus_ack  in  1  bus completion; sampled only in BUSY

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, i_en=1, legal access: register address, write data, byte enables and f3 -> BUSY.
- IDLE, i_en=1, illegal access: issue no bus request -> DONE with the error flag set.
- BUSY: o_bus_en=1 and all bus outputs held stable.
  - i_bus_ack=1: capture i_bus_rdata -> DONE.
  - Timeout counter reaches TIMEOUT: -> DONE, o_err=1, o_rdata=0.
- DONE: always -> IDLE after one cycle.
- o_stall = i_en && state != DONE. The stall is released in DONE, so the pipeline advances at the end of that cycle.
- Legal f3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code (including loads 011/110/111 and stores with f3[2]=1) -> o_err, no bus access.
- Byte enables: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
- Store data: byte replicated to all 4 lanes, half to both halves, word unchanged.
- Load data: byte at addr[1:0] or half at addr[1], shifted to bit 0, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Stores: o_rdata is 0 in DONE.
- Outside DONE: o_rdata, o_err and o_misaligned are 0.
- Reset values of all outputs are 0; state = IDLE; counter = 0.
- Reset mid-transaction: -> IDLE on the next edge and o_bus_en drops.
- i_bus_ack received in IDLE or DONE is ignored.

## Timing
- All bus outputs are registered; o_bus_en rises the cycle after i_en is seen in IDLE.
- Zero-wait-state bus (ack in the first BUSY cycle): stall cycles are IDLE and BUSY, DONE in cycle 2, so each access costs 2 stall cycles.
- Each additional wait state adds one cycle.
- Error paths (illegal f3, misaligned) go IDLE -> DONE: 1 stall cycle, no bus activity.
- The timeout counter counts BUSY cycles. It is ceil(log2(TIMEOUT+1)) bits wide, cleared on entry to BUSY, and saturates.
- If ack and timeout fall in the same cycle, ack wins and o_err=0.
- Back-to-back ops: a new i_en in the cycle after DONE starts a fresh transaction from IDLE.

## Configuration
- MEM_LSU_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is misaligned.
  - A misaligned access causes no bus access and takes 1 stall cycle.
  - o_misaligned=1 in DONE; o_err stays 0.
- Undefined:
  - o_misaligned is tied to 0.
  - Ignored address bits are forced to 0: halfword uses addr[1] only, word ignores addr[1:0].

## Structure
- Package arvi_mem_pkg holds:
  - the lsu_state_t enum;
  - the funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the be_t typedef (logic [3:0]).
- Sub-module mem_align (combinational) produces byte enables and store lane steering, and performs load extraction/extension.
- mem_lsu holds the FSM, the timeout counter and the registers.

## Test plan
- LW at 0x100, ack in the first BUSY cycle, i_bus_rdata=0xDEADBEEF -> o_bus_be=1111, o_rdata=0xDEADBEEF in DONE, 2 stall cycles.
- LB at 0x103 with rdata=0x80FFFFFF -> 0xFFFFFF80; LBU -> 0x00000080; LHU at 0x102 -> 0x000080FF.
- SB at 0x201, wdata=0x000000AB -> o_bus_be=0010, o_bus_wdata=0xABABABAB, o_bus_addr=0x200, o_bus_we=1.
- No ack with TIMEOUT=4 -> 4 BUSY cycles, then DONE with o_err=1 and o_rdata=0; ack arriving in the 4th BUSY cycle -> o_err=0.
- LW at 0x102: with macro, o_misaligned=1 and o_bus_en never asserted; without macro, o_bus_addr=0x100 and a normal load.
- i_rst low during BUSY -> o_bus_en=0 and state IDLE next cycle; a later ack is ignored and the next i_en starts cleanly.
